// File: rtl/fpu_pkg.sv
// Shared opcode, flag-bit and FSM definitions for the FPU op sequencer.
package fpu_pkg;

    localparam logic [3:0] FOP_ADD = 4'd0;
    localparam logic [3:0] FOP_SUB = 4'd1;
    localparam logic [3:0] FOP_MUL = 4'd2;
    localparam logic [3:0] FOP_DIV = 4'd3;
    localparam logic [3:0] FOP_INV = 4'd4;
    localparam logic [3:0] FOP_ABS = 4'd5;
    localparam logic [3:0] FOP_COM = 4'd6;
    localparam logic [3:0] FOP_BLT = 4'd7;
    localparam logic [3:0] FOP_BEQ = 4'd8;
    localparam logic [3:0] FOP_BGT = 4'd9;

    localparam int NUM_OPS = 10;

    localparam int FLG_OVFL = 0;
    localparam int FLG_UNFL = 1;
    localparam int FLG_INEX = 2;
    localparam int FLG_SNAN = 3;
    localparam int FLG_QNAN = 4;
    localparam int FLG_DIVZ = 5;
    localparam int FLG_ILL  = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    function automatic logic is_branch(input logic [3:0] op);
        return (op == FOP_BLT) || (op == FOP_BEQ) || (op == FOP_BGT);
    endfunction

endpackage

// File: rtl/fpu_op_decode.sv
// Combinational opcode -> one-hot ALU strobe vector; branches also raise COM.
// Opcodes above BGT produce no strobes and flag illegal.
module fpu_op_decode
    import fpu_pkg::*;
(
    input  logic [3:0]         op_i,
    output logic [NUM_OPS-1:0] strb_o,
    output logic               illegal_o
);

    always_comb begin
        strb_o    = '0;
        illegal_o = 1'b0;
        if (op_i > FOP_BGT) begin
            illegal_o = 1'b1;
        end else begin
            strb_o[op_i] = 1'b1;
            if (is_branch(op_i)) strb_o[FOP_COM] = 1'b1;
        end
    end

endmodule

// File: rtl/fpu_op_sequencer.sv
// Issues one FP op at a time to the strobe-driven ALU, captures its result after ALU_LAT cycles,
// pulses writeback/branch outcome and accumulates sticky flags. Optional trap logic: FPU_SEQ_EXC_TRAP_EN.
module fpu_op_sequencer
    import fpu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ALU_LAT = 1,
    parameter int RD_W    = 5
) (
`ifdef FPU_SEQ_EXC_TRAP_EN
    input  logic [5:0]        trap_mask,
    output logic              trap,
`endif
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [RD_W-1:0]   req_rd,
    output logic [DATA_W-1:0] operand1,
    output logic [DATA_W-1:0] operand2,
    output logic              ADD,
    output logic              SUB,
    output logic              MUL,
    output logic              DIV,
    output logic              INV,
    output logic              ABS,
    output logic              COM,
    output logic              BLT,
    output logic              BEQ,
    output logic              BGT,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_com,
    input  logic [5:0]        alu_flags,
    output logic              wb_valid,
    output logic [RD_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              br_valid,
    output logic              br_taken,
    input  logic              flags_clr,
    output logic [6:0]        fflags
);

    localparam int CNT_W = $clog2(ALU_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(ALU_LAT);

    seq_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_OPS-1:0] strb_q, strb_d;
    logic               ill_q, ill_d;
    logic [DATA_W-1:0]  a_q, a_d, b_q, b_d;
    logic [RD_W-1:0]    rd_q, rd_d;
    logic [DATA_W-1:0]  res_q, res_d;
    logic               com_q, com_d;
    logic [5:0]         flg_q, flg_d;
    logic [6:0]         fflags_q, fflags_d;

    logic [NUM_OPS-1:0] dec_strb;
    logic               dec_ill;
    logic [NUM_OPS-1:0] strobes;
    logic               br_op;
    logic               trap_hit;

    // Decode once at accept; the registered strobe vector then drives the ALU directly.
    fpu_op_decode u_decode (
        .op_i      (req_op),
        .strb_o    (dec_strb),
        .illegal_o (dec_ill)
    );

    assign br_op = |strb_q[FOP_BGT:FOP_BLT];

`ifdef FPU_SEQ_EXC_TRAP_EN
    assign trap_hit = (state_q == ST_DONE) && |(flg_q & trap_mask);
    assign trap     = trap_hit;
`else
    assign trap_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        strb_d    = strb_q;
        ill_d     = ill_q;
        a_d       = a_q;
        b_d       = b_q;
        rd_d      = rd_q;
        res_d     = res_q;
        com_d     = com_q;
        flg_d     = flg_q;
        fflags_d  = fflags_q;
        req_ready = (state_q == ST_IDLE);
        strobes   = '0;
        wb_valid  = 1'b0;
        br_valid  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    strb_d  = dec_strb;
                    ill_d   = dec_ill;
                    a_d     = req_a;
                    b_d     = req_b;
                    rd_d    = req_rd;
                    cnt_d   = '0;
                    flg_d   = '0;
                    state_d = dec_ill ? ST_DONE : ST_EXEC;
                end
            end
            ST_EXEC: begin
                strobes = strb_q;
                cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    res_d   = alu_result;
                    com_d   = alu_com;
                    flg_d   = alu_flags;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!ill_q && !trap_hit) begin
                    br_valid = br_op;
                    wb_valid = !br_op;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Clear first so flags captured in the same cycle are kept.
        if (flags_clr) fflags_d = '0;
        if (state_q == ST_DONE) fflags_d = fflags_d | {ill_q, flg_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            strb_q   <= '0;
            ill_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            rd_q     <= '0;
            res_q    <= '0;
            com_q    <= 1'b0;
            flg_q    <= '0;
            fflags_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            strb_q   <= strb_d;
            ill_q    <= ill_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rd_q     <= rd_d;
            res_q    <= res_d;
            com_q    <= com_d;
            flg_q    <= flg_d;
            fflags_q <= fflags_d;
        end
    end

    assign operand1 = a_q;
    assign operand2 = b_q;
    assign wb_rd    = rd_q;
    assign wb_data  = res_q;
    assign br_taken = br_valid & com_q;
    assign fflags   = fflags_q;

    assign ADD = strobes[FOP_ADD];
    assign SUB = strobes[FOP_SUB];
    assign MUL = strobes[FOP_MUL];
    assign DIV = strobes[FOP_DIV];
    assign INV = strobes[FOP_INV];
    assign ABS = strobes[FOP_ABS];
    assign COM = strobes[FOP_COM];
    assign BLT = strobes[FOP_BLT];
    assign BEQ = strobes[FOP_BEQ];
    assign BGT = strobes[FOP_BGT];

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Bench for fpu_op_sequencer: transaction-level model with per-cycle compare, directed cases, random traffic.
module tb_fpu_op_sequencer;

    localparam int DW  = 32;
    localparam int RW  = 5;
    localparam int LAT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Main instance (ALU_LAT=3)
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [3:0]    req_op = '0;
    logic [DW-1:0] req_a = '0, req_b = '0;
    logic [RW-1:0] req_rd = '0;
    logic [DW-1:0] operand1, operand2;
    wire  [9:0]    strb;
    logic [DW-1:0] alu_result;
    logic          alu_com;
    logic [5:0]    flags_drv = '0;
    logic          wb_valid, br_valid, br_taken;
    logic [RW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          flags_clr = 1'b0;
    logic [6:0]    fflags;
`ifdef FPU_SEQ_EXC_TRAP_EN
    logic [5:0]    trap_mask = '0;
    logic          trap;
`endif

    // Second instance (ALU_LAT=1), directed only
    logic          v1 = 1'b0, rdy1;
    logic [3:0]    op1 = '0;
    logic [DW-1:0] a1 = '0, b1 = '0, opd1_1, opd2_1, res1, wbd1;
    logic [RW-1:0] rd1 = '0, wbrd1;
    wire  [9:0]    strb1;
    logic          com1, wbv1, brv1, brt1;
    logic [6:0]    ff1;
`ifdef FPU_SEQ_EXC_TRAP_EN
    logic          trap1;
`endif

    function automatic logic [DW-1:0] alu_res(input int op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a * b;
            3: return (b == 0) ? '1 : a / b;
            4: return ~a;
            5: return {1'b0, a[DW-2:0]};
            default: return '0;
        endcase
    endfunction

    function automatic logic alu_cmp(input int op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            7: return a < b;
            8: return a == b;
            9: return a > b;
            default: return 1'b0;
        endcase
    endfunction

    // Behavioural ALU: identifies the requested op from the strobes; garbage when none are up.
    always_comb begin
        int sel;
        sel = -1;
        for (int i = 0; i < 10; i++)
            if (strb[i] && !(i == 6 && |strb[9:7])) sel = i;
        alu_result = (sel < 0) ? 32'hDEADBEEF : alu_res(sel, operand1, operand2);
        alu_com    = (sel < 0) ? 1'b0 : alu_cmp(sel, operand1, operand2);
    end

    always_comb begin
        int sel;
        sel = -1;
        for (int i = 0; i < 10; i++)
            if (strb1[i] && !(i == 6 && |strb1[9:7])) sel = i;
        res1 = (sel < 0) ? 32'hDEADBEEF : alu_res(sel, opd1_1, opd2_1);
        com1 = (sel < 0) ? 1'b0 : alu_cmp(sel, opd1_1, opd2_1);
    end

    fpu_op_sequencer #(.DATA_W(DW), .ALU_LAT(LAT), .RD_W(RW)) u_dut (
`ifdef FPU_SEQ_EXC_TRAP_EN
        .trap_mask (trap_mask),
        .trap      (trap),
`endif
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_rd     (req_rd),
        .operand1   (operand1),
        .operand2   (operand2),
        .ADD        (strb[0]),
        .SUB        (strb[1]),
        .MUL        (strb[2]),
        .DIV        (strb[3]),
        .INV        (strb[4]),
        .ABS        (strb[5]),
        .COM        (strb[6]),
        .BLT        (strb[7]),
        .BEQ        (strb[8]),
        .BGT        (strb[9]),
        .alu_result (alu_result),
        .alu_com    (alu_com),
        .alu_flags  (flags_drv),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .br_valid   (br_valid),
        .br_taken   (br_taken),
        .flags_clr  (flags_clr),
        .fflags     (fflags)
    );

    fpu_op_sequencer #(.DATA_W(DW), .ALU_LAT(1), .RD_W(RW)) u_dut1 (
`ifdef FPU_SEQ_EXC_TRAP_EN
        .trap_mask (6'b000000),
        .trap      (trap1),
`endif
        .clk        (clk),
        .rst        (rst),
        .req_valid  (v1),
        .req_ready  (rdy1),
        .req_op     (op1),
        .req_a      (a1),
        .req_b      (b1),
        .req_rd     (rd1),
        .operand1   (opd1_1),
        .operand2   (opd2_1),
        .ADD        (strb1[0]),
        .SUB        (strb1[1]),
        .MUL        (strb1[2]),
        .DIV        (strb1[3]),
        .INV        (strb1[4]),
        .ABS        (strb1[5]),
        .COM        (strb1[6]),
        .BLT        (strb1[7]),
        .BEQ        (strb1[8]),
        .BGT        (strb1[9]),
        .alu_result (res1),
        .alu_com    (com1),
        .alu_flags  (6'b000000),
        .wb_valid   (wbv1),
        .wb_rd      (wbrd1),
        .wb_data    (wbd1),
        .br_valid   (brv1),
        .br_taken   (brt1),
        .flags_clr  (1'b0),
        .fflags     (ff1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: an accepted op occupies the sequencer from its accept cycle k0
    // until k0+LAT+1 (k0+1 when illegal); strobes in k0+1..k0+LAT; pulse in the last cycle.
    int            cyc = 0, k0 = 0, done_c = 0, free_at = 0, m_op = 0;
    bit            armed = 0, act = 0, m_ill = 0;
    logic [DW-1:0] m_a, m_b, exp_op1, exp_op2;
    logic [RW-1:0] m_rd;
    logic [5:0]    m_fl;
    logic [6:0]    m_ff;
    logic          rdy_neg = 1'b0;

    always @(negedge clk) begin
        logic       exp_rdy, exp_wb, exp_br, exp_tr, is_done;
        logic [9:0] exp_strb;
        logic [6:0] newf;
        rdy_neg = req_ready;
        if (!armed) begin
            if (rst) begin
                armed = 1; m_ff = '0; act = 0; free_at = cyc + 1; exp_op1 = '0; exp_op2 = '0;
            end
        end else begin
            exp_rdy = (cyc >= free_at);
            exp_strb = '0; exp_wb = 0; exp_br = 0; exp_tr = 0; is_done = 0; newf = '0;
            if (act) begin
                if (!m_ill && cyc > k0 && cyc <= k0 + LAT) begin
                    exp_strb = 10'd1 << m_op;
                    if (m_op >= 7) exp_strb[6] = 1'b1;
                end
                if (cyc == done_c) begin
                    is_done = 1;
                    if (m_ill) newf = 7'h40;
                    else begin
                        newf = {1'b0, m_fl};
`ifdef FPU_SEQ_EXC_TRAP_EN
                        exp_tr = (m_fl & trap_mask) != 0;
`endif
                        if (!exp_tr) begin
                            if (m_op >= 7) exp_br = 1; else exp_wb = 1;
                        end
                    end
                end
            end
            chk("req_ready", req_ready, exp_rdy);
            chk("strobes", strb, exp_strb);
            chk("wb_valid", wb_valid, exp_wb);
            chk("br_valid", br_valid, exp_br);
            chk("fflags", fflags, m_ff);
            chk("operand1", operand1, exp_op1);
            chk("operand2", operand2, exp_op2);
            if (exp_wb) begin
                chk("wb_rd", wb_rd, m_rd);
                chk("wb_data", wb_data, alu_res(m_op, m_a, m_b));
            end
            if (exp_br) chk("br_taken", br_taken, alu_cmp(m_op, m_a, m_b));
`ifdef FPU_SEQ_EXC_TRAP_EN
            chk("trap", trap, exp_tr);
`endif
            if (is_done) begin
                m_ff = (flags_clr ? 7'h00 : m_ff) | newf;
                act = 0;
            end else if (flags_clr) m_ff = '0;
            if (exp_rdy && req_valid) begin
                act = 1; k0 = cyc; m_op = int'(req_op); m_a = req_a; m_b = req_b; m_rd = req_rd;
                m_fl = flags_drv; m_ill = (req_op > 4'd9);
                done_c = m_ill ? cyc + 1 : cyc + LAT + 1;
                free_at = done_c + 1;
                exp_op1 = req_a; exp_op2 = req_b;
            end
            if (rst) begin
                m_ff = '0; act = 0; free_at = cyc + 1; exp_op1 = '0; exp_op2 = '0;
            end
        end
        cyc++;
    end

    // Called just after a rising edge; returns just after the accept edge (cycle 1).
    task automatic send(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [RW-1:0] rd, input logic [5:0] fl);
        int n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("send_ready", req_ready, 1'b1);
        req_op = op; req_a = a; req_b = b; req_rd = rd; flags_drv = fl; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_strobes", strb, 10'd0);
        chk("rst_fflags", fflags, 7'd0);

        // ALU_LAT=1 ADD 3+4 -> rd 5
        @(posedge clk); #1;
        v1 = 1'b1; op1 = 4'd0; a1 = 32'd3; b1 = 32'd4; rd1 = 5'd5;
        @(posedge clk); #1 v1 = 1'b0;
        @(negedge clk);
        chk("t1_strb_c1", strb1, 10'b0000000001);
        @(negedge clk);
        chk("t1_strb_c2", strb1, 10'd0);
        chk("t1_wb_valid", wbv1, 1'b1);
        chk("t1_wb_rd", wbrd1, 5'd5);
        chk("t1_wb_data", wbd1, 32'd7);
        @(negedge clk);
        chk("t1_wb_c3", wbv1, 1'b0);
        chk("t1_ready_c3", rdy1, 1'b1);

        // BLT 1<2, LAT=3
        @(posedge clk); #1;
        send(4'd7, 32'd1, 32'd2, 5'd9, 6'd0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("t2_strb", strb, 10'b0011000000);
        end
        @(negedge clk);
        chk("t2_br_valid", br_valid, 1'b1);
        chk("t2_br_taken", br_taken, 1'b1);
        chk("t2_wb_valid", wb_valid, 1'b0);
        chk("t2_strb_done", strb, 10'd0);

        // Sticky accumulation then clear
        @(posedge clk); #1;
        send(4'd3, 32'd10, 32'd2, 5'd1, 6'b100000);
        send(4'd2, 32'd3, 32'd5, 5'd2, 6'b000100);
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        chk("t3_fflags", fflags, 7'b0100100);
        @(posedge clk); #1 flags_clr = 1'b1;
        @(posedge clk); #1 flags_clr = 1'b0;
        @(negedge clk);
        chk("t3_clr", fflags, 7'd0);

        // Illegal opcode
        @(posedge clk); #1;
        send(4'd12, 32'd1, 32'd1, 5'd3, 6'd0);
        @(negedge clk);
        chk("t4_ready_c1", req_ready, 1'b0);
        chk("t4_strb", strb, 10'd0);
        chk("t4_wb", wb_valid, 1'b0);
        chk("t4_br", br_valid, 1'b0);
        @(negedge clk);
        chk("t4_ready_c2", req_ready, 1'b1);
        chk("t4_fflags", fflags, 7'b1000000);
        @(posedge clk); #1 flags_clr = 1'b1;
        @(posedge clk); #1 flags_clr = 1'b0;

        // Reset during EXEC cycle 1 of SUB
        send(4'd1, 32'd5, 32'd3, 5'd2, 6'b000001);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_strb_c1", strb, 10'b0000000010);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_strb", strb, 10'd0);
        chk("t5_ready", req_ready, 1'b1);
        chk("t5_fflags", fflags, 7'd0);
        for (int c = 0; c < 4; c++) begin
            chk("t5_no_wb", wb_valid, 1'b0);
            @(negedge clk);
        end

`ifdef FPU_SEQ_EXC_TRAP_EN
        @(posedge clk); #1 trap_mask = 6'b100000;
        send(4'd3, 32'd8, 32'd0, 5'd4, 6'b100000);
        repeat (4) @(negedge clk);
        chk("t6_trap", trap, 1'b1);
        chk("t6_wb", wb_valid, 1'b0);
        @(negedge clk);
        chk("t6_fflags_divz", fflags[5], 1'b1);
        chk("t6_trap_off", trap, 1'b0);
        @(posedge clk); #1 trap_mask = 6'b000000; flags_clr = 1'b1;
        @(posedge clk); #1 flags_clr = 1'b0;
`endif

        // Random traffic, clears and resets
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            if (req_valid && rdy_neg) req_valid = 1'b0;
            flags_clr = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 79) == 0);
            if (!req_valid && req_ready && $urandom_range(0, 2) != 0) begin
                req_op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
                req_a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
                req_b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
                req_rd = 5'($urandom);
                flags_drv = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
                req_valid = 1'b1;
            end
        end
        req_valid = 1'b0; rst = 1'b0; flags_clr = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
